// File: rtl/term_feeder.sv
// rtl/term_feeder.sv - byte FIFO feeding a polled terminal
// Each byte is sent as: status read, ready check, data write, hold cycle.
module term_feeder #(
  parameter int DEPTH      = 16,
  parameter int STATUS_BIT = 1,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       n_rd,
  output logic                       n_wr,
  output logic                       regSel,
  output logic [7:0]                 bus_dout,
  input  logic [7:0]                 bus_din,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       stalled
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [LW-1:0] FULL  = LW'(DEPTH);
  localparam logic [PW-1:0] LIMIT = PW'(POLL_LIMIT);

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, REL} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [PW-1:0]   poll_cnt;
  logic            ready;
  logic            push, pop;
  logic            n_rd_nx, n_wr_nx, sel_nx;
  logic            unused_din_bits;

  assign unused_din_bits = ^bus_din;

  assign in_ready = n_reset && (fifo_level != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == WR) && (fifo_level != '0);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fifo_level != '0) state_n = RD;
      RD:      state_n = CHK;
      CHK:     state_n = ready ? WR : RD;
      WR:      state_n = REL;
      REL:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Strobes are registered from the next state so they align with it.
    n_rd_nx = (state_n != RD);
    n_wr_nx = (state_n != WR);
    sel_nx  = (state_n == WR) || (state_n == REL);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      n_rd       <= 1'b1;
      n_wr       <= 1'b1;
      regSel     <= 1'b0;
      bus_dout   <= 8'h00;
      ready      <= 1'b0;
      poll_cnt   <= '0;
      stalled    <= 1'b0;
    end else begin
      state  <= state_n;
      n_rd   <= n_rd_nx;
      n_wr   <= n_wr_nx;
      regSel <= sel_nx;
      if (state_n == WR) bus_dout <= mem[rptr];

      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      if (state == RD) ready <= bus_din[STATUS_BIT];

      if (state == CHK) begin
        if (ready) begin
          poll_cnt <= '0;
        end else begin
          if (poll_cnt != LIMIT) poll_cnt <= poll_cnt + 1'b1;
          if (poll_cnt >= LIMIT - 1'b1) stalled <= 1'b1;
        end
      end
      if (state == WR) stalled <= 1'b0;
    end
  end
endmodule
